osd_ram_write_arbiter: RTL
==========================

# osd_ram_write_arbiter

Shares the single write port of the OSD character RAM (2048 × 8, dual-port, read side owned by the overlay renderer) among several independent writers. Typical writers are the string writer, the binary-to-ASCII value writer and the direct offset/sign writer in the OSD top level. Arbitration is round-robin with optional burst locking, so a multi-character field is never interleaved with another writer's characters. An optional mode restricts writes to vertical blanking. The block replaces the ad-hoc OR/priority mux on the RAM write port.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters, range 2..8.
- ADDR_WIDTH, 11: character RAM address width.
- DATA_WIDTH, 8: character code width.
- BLANK_ONLY, 0: when 1, beats are accepted only while vblank is high.
- MAX_BURST, 64: maximum accepted beats per locked ownership before a forced release; range 2..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester write beat valid.
- req_lock  in  NUM_REQ  per-requester request to keep ownership after the current beat.
- req_addr  in  NUM_REQ×ADDR_WIDTH  per-requester beat address; packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ×DATA_WIDTH  per-requester beat data; packed the same way.
- req_ready  out  NUM_REQ  beat accepted this cycle; combinational, at most one bit high.
- vblank  in  1  vertical blanking, synchronous to clk; used only when BLANK_ONLY=1.
- wr_en  out  1  RAM write enable; registered.
- wr_addr  out  ADDR_WIDTH  RAM write address; registered.
- wr_data  out  DATA_WIDTH  RAM write data; registered.
- owner_id  out  $clog2(NUM_REQ)  current or last owner; registered.
- locked  out  1  state is LOCKED.
- lock_timeout  out  1  single-cycle pulse on forced release.

## Operation
- **Handshake:** a beat transfers when req_valid[i] && req_ready[i]. A requester holds valid, addr and data stable until ready. Valid must not wait on ready.
- **States:** IDLE and LOCKED.
- **Permission:** permit = BLANK_ONLY ? vblank : 1.
- **IDLE:**
  - If permit and any req_valid is set, grant the first valid requester at or after rr_ptr, scanning upward with wrap. Only that requester's ready goes high.
  - On acceptance: rr_ptr ← winner+1 mod NUM_REQ, and owner_id ← winner.
  - If req_lock[winner] is high on the accepted beat, go to LOCKED with burst_cnt ← 1.
- **LOCKED:**
  - Only the owner may get ready, and only when permit is high. All other requesters are stalled.
  - Each accepted beat increments burst_cnt.
  - Release to IDLE on any of these:
    - an accepted beat with req_lock low;
    - the owner has req_valid low and req_lock low in the same cycle;
    - burst_cnt reaches MAX_BURST on an accepted beat. This is a forced release: lock_timeout pulses on the next cycle.
  - rr_ptr is already past the owner, so the other requesters get the next grant.
- **Blanking in LOCKED:** if permit drops, ownership is kept and ready stays low. The burst resumes when vblank rises again.
- **Write path:** an accepted beat is registered to wr_addr/wr_data with wr_en=1 one cycle later. wr_en=0 otherwise, and wr_addr/wr_data hold their last value.
- **Widths:** burst_cnt is 8 bits. rr_ptr wraps modulo NUM_REQ, including non-power-of-two NUM_REQ.

## Timing
- **Reset values:** state IDLE, rr_ptr 0, burst_cnt 0, wr_en 0, wr_addr 0, wr_data 0, owner_id 0, locked 0, lock_timeout 0, req_ready all 0 during reset.
- **Latency:** acceptance at cycle N gives wr_en high at N+1. Back-to-back beats are allowed, giving 1 write per cycle sustained.
- **Arbitration:** a grant decision takes 0 cycles (same cycle as valid). Switching owners costs no idle cycle.
- **Locked release:** the cycle after release is IDLE and arbitrates normally.
- **Reset mid-burst:** takes effect the next cycle with no write issued. A beat accepted in the reset cycle is dropped.
- **Simultaneous valid after reset:** requester 0 wins first, then 1, then 2.
- **Lock timing:** req_lock is sampled only on accepted beats, plus the release check in LOCKED.

## Structure
- In xain_pkg: arb_state_t (IDLE, LOCKED), OSD_RAM_ADDR_W = 11 and OSD_RAM_DATA_W = 8.
- Sub-module rr_priority_picker: combinational; inputs a request vector and a start pointer; outputs a one-hot grant and a grant index. It is reused by future OSD resource arbiters.

## Test plan
- **Simultaneous single beats:** req 0, 1, 2 all valid at once with lock=0, addrs 0x100/0x200/0x300 → accepted in order 0, 1, 2 on consecutive cycles; wr_en for 3 cycles starting 1 cycle after the first accept; wr_addr 0x100, 0x200, 0x300.
- **Locked burst:** req1 does a locked 5-beat burst to 0x318..0x31C (lock high on beats 1–4, low on beat 5) while req0 is valid throughout → req0 gets no ready until after beat 5; 5 contiguous writes; req0's first write is 1 cycle after the burst's last write.
- **Forced release:** MAX_BURST=4, req2 holds lock for 10 beats → release after beat 4; lock_timeout pulses once; waiting req0 is granted next.
- **Blank-only mode:** BLANK_ONLY=1, vblank low, req0 valid → no ready. Raise vblank → accept on the same cycle. Mid-burst vblank falls for 3 cycles → burst stalls, ownership is kept, and it resumes when vblank rises.
- **Reset mid-burst:** reset asserted during beat 3 of a locked burst → next cycle wr_en=0, locked=0, rr_ptr=0; after release req0 wins a contention against req2.

Source files
------------

// File: rtl/xain_pkg.sv
// Shared types and constants for the OSD character RAM and its write-port arbiters.
package xain_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int OSD_RAM_ADDR_W = 11;
  localparam int OSD_RAM_DATA_W = 8;

  // Round-robin pointer advance that also handles non-power-of-two requester counts.
  function automatic int wrap_inc(input int idx, input int modulus);
    return (idx + 1 >= modulus) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after start_i, scanning upward with wrap.
module rr_priority_picker #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 any_o
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W:0] pos;
  logic           found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    pos       = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, start_i} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        found                   = 1'b1;
        gnt_idx_o               = pos[IDX_W-1:0];
        gnt_o[pos[IDX_W-1:0]]   = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/osd_ram_write_arbiter.sv
// Round-robin arbiter with burst locking for the single write port of the OSD character RAM.
module osd_ram_write_arbiter
  import xain_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = OSD_RAM_ADDR_W,
  parameter int DATA_WIDTH = OSD_RAM_DATA_W,
  parameter bit BLANK_ONLY = 1'b0,
  parameter int MAX_BURST  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          vblank,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic                          locked,
  output logic                          lock_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t      state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic [7:0]       cnt_inc;
  logic             timeout_q, timeout_d;
  logic             wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic             permit;
  logic             accept;
  logic [IDX_W-1:0] sel_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  assign permit = BLANK_ONLY ? vblank : 1'b1;

  rr_priority_picker #(.N(NUM_REQ)) u_picker (
    .req_i     (req_valid),
    .start_i   (rr_ptr_q),
    .gnt_o     (pick_gnt),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    timeout_d   = 1'b0;
    req_ready   = '0;
    accept      = 1'b0;
    sel_idx     = owner_q;
    cnt_inc     = burst_cnt_q + 8'd1;
    unique case (state_q)
      ARB_IDLE: begin
        if (permit && pick_any) begin
          req_ready = pick_gnt;
          accept    = 1'b1;
          sel_idx   = pick_idx;
          owner_d   = pick_idx;
          rr_ptr_d  = IDX_W'(wrap_inc(int'(pick_idx), NUM_REQ));
          if (req_lock[pick_idx]) begin
            state_d     = ARB_LOCKED;
            burst_cnt_d = 8'd1;
          end
        end
      end
      ARB_LOCKED: begin
        // rr_ptr already points past the owner, so a release hands the next grant to the others.
        if (permit && req_valid[owner_q]) begin
          req_ready[owner_q] = 1'b1;
          accept             = 1'b1;
          burst_cnt_d        = cnt_inc;
          if (cnt_inc == 8'(MAX_BURST)) begin
            state_d     = ARB_IDLE;
            burst_cnt_d = '0;
            timeout_d   = 1'b1;
          end else if (!req_lock[owner_q]) begin
            state_d     = ARB_IDLE;
            burst_cnt_d = '0;
          end
        end else if (!req_valid[owner_q] && !req_lock[owner_q]) begin
          state_d     = ARB_IDLE;
          burst_cnt_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // A beat presented during reset is never accepted.
    if (reset) begin
      req_ready = '0;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      timeout_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      timeout_q   <= timeout_d;
      wr_en_q     <= accept;
      if (accept) begin
        wr_addr_q <= req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data_q <= req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign owner_id     = owner_q;
  assign locked       = (state_q == ARB_LOCKED);
  assign lock_timeout = timeout_q;

endmodule
